sbox_array: RTL and testbench

SBOX_ARRAY -- requirements
Module: sbox_array

---
 rtl/sbox_array.sv | 161 ++++++++++++++++
 tb/tb_sbox_array.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_array.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_array
//  Purpose  : Folded AES byte-substitution engine. A block of LANES bytes is
//             captured, then NSBOX bytes per cycle are replaced in place by
//             the FIPS-197 S-box (SubBytes) or inverse S-box (InvSubBytes).
//             The block is emitted after FOLD = LANES/NSBOX beats.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        rising-edge clock
//    rst        in   1        synchronous active-high reset
//    in_valid   in   1        input block offered
//    in_ready   out  1        engine idle, can accept a block
//    in_data    in   8*LANES  input block, byte i = in_data[8i+7:8i]
//    in_inv     in   1        0 = forward S-box, 1 = inverse S-box
//    out_valid  out  1        result block available
//    out_ready  in   1        downstream accepts the result
//    out_data   out  8*LANES  substituted block, same byte order
//    busy       out  1        engine not idle
// ============================================================================
module sbox_array #(
   parameter int LANES = 16,
   parameter int NSBOX = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   input  logic               in_inv,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic               busy
);

   localparam int FOLD   = LANES / NSBOX;
   localparam int CW_RAW = $clog2(FOLD + 1);
   localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam int LW_RAW = $clog2(LANES);
   localparam int LW     = (LW_RAW < 1) ? 1 : LW_RAW;
   localparam logic [CW-1:0] LAST_BEAT = CW'(FOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_beat;
   logic          r_inv;
   logic [7:0]    r_work [LANES];

   logic [LW-1:0] w_lane [NSBOX];
   logic [7:0]    w_pre  [NSBOX];
   logic [7:0]    w_gi   [NSBOX];
   logic [7:0]    w_sub  [NSBOX];

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (= a^2 * a^4 * ... * a^128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   // Forward affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   // Each lane shares one field inverter between both directions:
   // forward = affine(inv(x)), inverse = inv(inv_affine(x)).
   for (genvar j = 0; j < NSBOX; j++) begin : g_lane
      assign w_lane[j] = LW'(int'(r_beat) * NSBOX + j);
      assign w_pre[j]  = r_inv ? inv_affine(r_work[w_lane[j]]) : r_work[w_lane[j]];
      assign w_gi[j]   = gf_inv(w_pre[j]);
      assign w_sub[j]  = r_inv ? w_gi[j] : affine(w_gi[j]);
   end

   for (genvar i = 0; i < LANES; i++) begin : g_out
      assign out_data[8*i +: 8] = r_work[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_beat    <= '0;
         r_inv     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < LANES; i++) r_work[i] <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < LANES; i++) r_work[i] <= in_data[8*i +: 8];
                  r_inv    <= in_inv;
                  r_beat   <= '0;
                  r_state  <= ST_RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ST_RUN: begin
               for (int j = 0; j < NSBOX; j++) r_work[w_lane[j]] <= w_sub[j];
               r_beat <= r_beat + 1'b1;
               if (r_beat == LAST_BEAT) begin
                  r_state   <= ST_DONE;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               // Returning to IDLE (not accepting) keeps the minimum period
               // at FOLD+2 cycles.
               if (out_ready) begin
                  r_state   <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sbox_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbox_array
//  Purpose  : Self-checking bench for sbox_array. Instance A uses LANES=16,
//             NSBOX=4 (FOLD=4); instance B uses NSBOX=16 (FOLD=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sbox_array;

   localparam int W = 128;

   logic         clk = 1'b0;
   logic         rst;

   logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_busy;
   logic [W-1:0] a_in_data, a_out_data;
   logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_busy;
   logic [W-1:0] b_in_data, b_out_data;

   int checks   = 0;
   int failures = 0;

   logic [7:0]   fwd_t [256];
   logic [7:0]   inv_t [256];
   logic [W-1:0] sb_a [$];
   logic [W-1:0] sb_b [$];

   always #5 clk = ~clk;

   sbox_array #(.LANES(16), .NSBOX(4)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_inv(a_in_inv),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
   );

   sbox_array #(.LANES(16), .NSBOX(16)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_inv(b_in_inv),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 0; x = a; y = b;
      while (y != 0) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Reference tables: brute-force field inverse, bitwise FIPS affine map,
   // inverse table obtained by inverting the forward table.
   task automatic build_tables();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                 ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 1);
         fwd_t[x] = s;
         inv_t[s] = 8'(x);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic inv);
      logic [W-1:0] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [W-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Offer a block to A (engine idle), push its expected result, and
   // scramble the inputs afterwards to show they are ignored.
   task automatic a_start(input logic [W-1:0] d, input logic inv, input logic [W-1:0] exp);
      sb_a.push_back(exp);
      a_in_valid = 1'b1; a_in_data = d; a_in_inv = inv;
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_in_data = rand128(); a_in_inv = ~inv;
   endtask

   task automatic a_wait(input string tag);
      int lat;
      lat = 0;
      while (!a_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, W'(lat), W'(4));
      if (sb_a.size() > 0) check({tag, "_data"}, a_out_data, sb_a.pop_front());
   endtask

   task automatic a_consume(input string tag);
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      check({tag, "_ready_back"}, W'(a_in_ready), W'(1));
      check({tag, "_valid_drop"}, W'(a_out_valid), W'(0));
   endtask

   task automatic a_block(input string tag, input logic [W-1:0] d, input logic inv,
                          input logic [W-1:0] exp);
      a_start(d, inv, exp);
      a_wait(tag);
      a_consume(tag);
   endtask

   initial begin
      logic [W-1:0] d;
      logic [W-1:0] held;
      int           nv;
      int           last_acc;
      int           nacc;
      int           nout;
      logic         acc_pend;

      build_tables();
      rst = 1'b1;
      a_in_valid = 1'b1; a_in_data = rand128(); a_in_inv = 1'b1; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_inv = 1'b0; b_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state, with in_valid asserted to show reset wins.
      check("rst_out_valid", W'(a_out_valid), W'(0));
      check("rst_busy",      W'(a_busy),      W'(0));
      check("rst_in_ready",  W'(a_in_ready),  W'(1));
      check("rst_out_data",  a_out_data,      W'(0));
      check("rst_b_ready",   W'(b_in_ready),  W'(1));
      a_in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      a_block("fwd_zero", '0, 1'b0, {16{8'h63}});
      a_block("fwd_fips", 128'h0848f8e92a8dc69a2be2f4a0bee33d19, 1'b0,
              128'h3052411ee55db4b8f198bfe0ae1127d4);
      a_block("inv_fips", 128'h3052411ee55db4b8f198bfe0ae1127d4, 1'b1,
              128'h0848f8e92a8dc69a2be2f4a0bee33d19);
      a_block("inv_63",   {16{8'h63}}, 1'b1, '0);
      a_block("inv_alt",  {8{16'h1600}}, 1'b1, {8{16'hff52}});
      d = rand128();
      a_block("fwd_rand", d, 1'b0, model(d, 1'b0));
      d = rand128();
      a_block("inv_rand", d, 1'b1, model(d, 1'b1));
      d = 128'hff53_0000_1234_5678_9abc_def0_ff53_a5c3;
      a_block("fwd_mix",  d, 1'b0, model(d, 1'b0));

      // Back-pressure in DONE with a competing input offered.
      d = rand128();
      a_start(d, 1'b0, model(d, 1'b0));
      held = model(d, 1'b0);
      a_wait("hold");
      a_in_valid = 1'b1; a_in_data = rand128(); a_in_inv = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("hold_valid", W'(a_out_valid), W'(1));
         check("hold_data",  a_out_data, held);
         check("hold_ready", W'(a_in_ready), W'(0));
      end
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      check("hold_ready_back", W'(a_in_ready), W'(1));
      check("hold_no_accept",  W'(a_busy),     W'(0));
      a_in_valid = 1'b0;
      @(posedge clk); #1;

      // Reset on beat k=2 discards the block in flight.
      a_in_valid = 1'b1; a_in_data = rand128(); a_in_inv = 1'b0;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mrst_out_valid", W'(a_out_valid), W'(0));
      check("mrst_busy",      W'(a_busy),      W'(0));
      check("mrst_in_ready",  W'(a_in_ready),  W'(1));
      check("mrst_out_data",  a_out_data,      W'(0));
      a_out_ready = 1'b1;
      nv = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (a_out_valid) nv++;
      end
      a_out_ready = 1'b0;
      check("mrst_no_result", W'(nv), W'(0));
      check("a_scoreboard_empty", W'(sb_a.size()), W'(0));

      // FOLD=1 instance: back-to-back traffic, out_ready held high.
      b_in_valid = 1'b1; b_out_ready = 1'b1;
      b_in_data = rand128(); b_in_inv = 1'b0;
      last_acc = 0; nacc = 0; nout = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (b_out_valid) begin
            check("b_latency", W'(c - last_acc), W'(2));
            if (sb_b.size() > 0) check("b_data", b_out_data, sb_b.pop_front());
            nout++;
         end
         acc_pend = b_in_valid && b_in_ready;
         if (acc_pend) begin
            sb_b.push_back(model(b_in_data, b_in_inv));
            if (nacc > 0) check("b_period", W'(c - last_acc), W'(3));
            last_acc = c;
            nacc++;
         end
         @(posedge clk); #1;
         if (acc_pend) begin
            b_in_data = rand128();
            b_in_inv  = 1'($urandom_range(0, 1));
         end
      end
      b_in_valid = 1'b0;
      check("b_accepts", W'(nacc), W'(5));
      check("b_outputs", W'(nout), W'(5));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
